// File: rtl/alu_acc_ctrl_pkg.sv
// Shared definitions for the ALU accumulator controller: ALU function codes and FSM state encoding.
package alu_acc_ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LTU = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Compare ops report through rsp_result only and leave the accumulator alone.
    function automatic logic is_compare(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_acc_ctrl.sv
// Accumulator-owning initiator for an external combinational ALU, with valid/ready command and response ports.
// Define ALU_PIPE_EN to register the ALU result at the end of ISSUE and capture it one cycle later in WAIT.
module alu_acc_ctrl
    import alu_acc_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [W-1:0] rsp_acc,
    output logic [2:0]   rsp_flags,
    output logic [3:0]   rsp_seq,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_f,
    input  logic [W-1:0] alu_y,
    input  logic         alu_zf,
    input  logic         alu_of,
    input  logic         alu_cf
);

    // Handshake rule for both ports: a transfer happens on a rising edge where valid & ready are both 1;
    // a raised rsp_valid and its payload hold unchanged until that transfer.

    state_t       state;
    logic [W-1:0] acc;
    logic [W-1:0] cap_y;
    logic [2:0]   cap_flags;
    logic         cap_now;
    logic [W-1:0] acc_next;

    // alu_b/alu_f double as the latched operand and op code for the command in flight.
    assign alu_a = acc;

`ifdef ALU_PIPE_EN
    logic [W-1:0] y_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            flags_q <= 3'b000;
        end else if (state == ST_ISSUE) begin
            y_q     <= alu_y;
            flags_q <= {alu_cf, alu_of, alu_zf};
        end
    end

    assign cap_y     = y_q;
    assign cap_flags = flags_q;
    assign cap_now   = (state == ST_WAIT);
`else
    assign cap_y     = alu_y;
    assign cap_flags = {alu_cf, alu_of, alu_zf};
    // WAIT is unreachable here; treating it like ISSUE keeps the FSM from sticking.
    assign cap_now   = (state == ST_ISSUE) || (state == ST_WAIT);
`endif

    assign acc_next = is_compare(alu_f) ? acc : cap_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_acc    <= '0;
            rsp_flags  <= 3'b000;
            rsp_seq    <= 4'd0;
            alu_b      <= '0;
            alu_f      <= ALU_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            acc        <= cmd_data;
                            rsp_result <= cmd_data;
                            rsp_acc    <= cmd_data;
                            rsp_flags  <= 3'b000;
                            rsp_valid  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            alu_b <= cmd_data;
                            alu_f <= cmd_op;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (cap_now) begin
                        acc        <= acc_next;
                        rsp_result <= cap_y;
                        rsp_acc    <= acc_next;
                        rsp_flags  <= cap_flags;
                        rsp_valid  <= 1'b1;
                        alu_b      <= '0;
                        alu_f      <= ALU_ADD;
                        state      <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_seq   <= rsp_seq + 4'd1;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl with a small combinational ALU model attached to its ALU port.
module tb_alu_acc_ctrl;
    import alu_acc_ctrl_pkg::*;

    localparam int W = 4;
`ifdef ALU_PIPE_EN
    localparam int LAT_OP = 3;
`else
    localparam int LAT_OP = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_load = 1'b0;
    logic [2:0]   cmd_op = 3'b000;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [W-1:0] rsp_acc;
    logic [2:0]   rsp_flags;
    logic [3:0]   rsp_seq;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_f;
    logic [W-1:0] alu_y;
    logic         alu_zf;
    logic         alu_of;
    logic         alu_cf;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [3:0]   exp_seq = 4'd0;

    alu_acc_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_acc(rsp_acc), .rsp_flags(rsp_flags), .rsp_seq(rsp_seq),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external ALU model: cf is carry (ADD) or borrow (SUB), of is signed overflow
    always_comb begin
        logic [W:0] t;
        t      = '0;
        alu_y  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (alu_f)
            ALU_ADD: begin
                t      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y  = t[W-1:0];
                alu_cf = t[W];
                alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            ALU_SUB: begin
                alu_y  = alu_a - alu_b;
                alu_cf = (alu_a < alu_b);
                alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
            end
            ALU_NOT: alu_y = ~alu_a;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
            ALU_LTU: alu_y = (alu_a < alu_b) ? W'(1) : W'(0);
            default: alu_y = (alu_a == alu_b) ? W'(1) : W'(0);
        endcase
        alu_zf = (alu_y == '0);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_f", alu_f, 0);
        rst_n = 1'b1;
        check("rel_cmd_ready_lo", cmd_ready, 0);
        step();
        check("rel_cmd_ready_hi", cmd_ready, 1);
        check("rel_acc_zero", alu_a, 0);
        exp_seq = 4'd0;
    endtask

    // offer one command, then wait for rsp_valid and check the latency
    task automatic send(input string tag, input logic ld, input logic [2:0] op, input logic [W-1:0] d);
        int n;
        int lat;
        n = 0;
        while (!cmd_ready && n < 10) begin
            step();
            n++;
        end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = W'($urandom_range(0, 15));
        check({tag, "_alu_f"}, alu_f, ld ? 3'b000 : op);
        check({tag, "_alu_b"}, alu_b, ld ? '0 : d);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, ld ? 1 : LAT_OP);
    endtask

    task automatic expect_rsp(input string tag, input logic [W-1:0] res, input logic [W-1:0] acc,
                              input logic [2:0] flags);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_result"}, rsp_result, res);
        check({tag, "_acc"}, rsp_acc, acc);
        check({tag, "_flags"}, rsp_flags, flags);
        check({tag, "_seq"}, rsp_seq, exp_seq);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_seq   = exp_seq + 4'd1;
        check("consume_valid_lo", rsp_valid, 0);
    endtask

    // scoreboard: expected results of the directed op chain, flags are {cf,of,zf}
    logic [W-1:0] exp_q[$];

    initial begin
        int prev_cyc;
        int n;

        // 1: reset
        do_reset();

        // 2: load 7, ADD 9 wraps to 0 with carry and zero
        send("ld7", 1'b1, ALU_ADD, 4'h7);
        expect_rsp("ld7", 4'h7, 4'h7, 3'b000);
        consume();
        send("add9", 1'b0, ALU_ADD, 4'h9);
        expect_rsp("add9", 4'h0, 4'h0, 3'b101);
        consume();

        // 3: compares leave acc untouched
        send("ld5", 1'b1, ALU_SUB, 4'h5);
        expect_rsp("ld5", 4'h5, 4'h5, 3'b000);
        consume();
        send("eq5", 1'b0, ALU_EQ, 4'h5);
        expect_rsp("eq5", 4'h1, 4'h5, 3'b000);
        consume();
        send("eq3", 1'b0, ALU_EQ, 4'h3);
        expect_rsp("eq3", 4'h0, 4'h5, 3'b001);
        consume();

        // op chain: 3-5=E (borrow), E^F=1, ~1=E, E<F=1 with acc kept at E
        exp_q.push_back(4'hE);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'hE);
        send("ld3", 1'b1, ALU_ADD, 4'h3);
        expect_rsp("ld3", 4'h3, 4'h3, 3'b000);
        consume();
        send("sub5", 1'b0, ALU_SUB, 4'h5);
        expect_rsp("sub5", exp_q[0], exp_q[0], 3'b100);
        consume();
        send("xorf", 1'b0, ALU_XOR, 4'hF);
        expect_rsp("xorf", exp_q[1], exp_q[1], 3'b000);
        consume();
        send("not6", 1'b0, ALU_NOT, 4'h6);
        expect_rsp("not6", exp_q[2], exp_q[2], 3'b000);
        consume();
        send("ltuf", 1'b0, ALU_LTU, 4'hF);
        expect_rsp("ltuf", 4'h1, 4'hE, 3'b000);
        consume();

        // 4: backpressure, a competing command must not be taken
        send("add1", 1'b0, ALU_ADD, 4'h1);
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 4'h3;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_rsp("bp", 4'hF, 4'hF, 3'b000);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        consume();
        step();
        check("bp_acc_kept", alu_a, 4'hF);

        // 5: 18 back-to-back loads, sequence wraps, one accept every 2 cycles
        do_reset();
        rsp_ready = 1'b1;
        prev_cyc  = 0;
        for (int i = 0; i < 18; i++) begin
            n = 0;
            while (!cmd_ready && n < 10) begin
                step();
                n++;
            end
            check("b2b_cmd_ready", cmd_ready, 1);
            if (i > 0) check("b2b_cadence", cyc - prev_cyc, 2);
            prev_cyc  = cyc;
            cmd_valid = 1'b1;
            cmd_load  = 1'b1;
            cmd_data  = W'(i);
            step();
            cmd_valid = 1'b0;
            cmd_load  = 1'b0;
            expect_rsp("b2b", W'(i), W'(i), 3'b000);
            exp_seq = exp_seq + 4'd1;
        end
        step();
        rsp_ready = 1'b0;
        check("b2b_seq_final", rsp_seq, 4'd2);

        // 6: reset during ISSUE of an ADD aborts it
        exp_seq = rsp_seq;
        send("ld9", 1'b1, ALU_ADD, 4'h9);
        expect_rsp("ld9", 4'h9, 4'h9, 3'b000);
        consume();
        n = 0;
        while (!cmd_ready && n < 10) begin
            step();
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = ALU_ADD;
        cmd_data  = 4'h2;
        step();
        cmd_valid = 1'b0;
        check("abort_issue_a", alu_a, 4'h9);
        check("abort_issue_f", alu_f, ALU_ADD);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu_f", alu_f, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_acc", alu_a, 0);
        check("abort_rsp_acc", rsp_acc, 0);
        check("abort_seq", rsp_seq, 0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_rel_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_acc_zero", alu_a, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
